resync_fifo: RTL and testbench

RESYNC_FIFO -- requirements
Module: resync_fifo

---
 rtl/resync_fifo.sv | 94 +++++++++
 tb/tb_resync_fifo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/resync_fifo.sv
// resync_fifo: single-clock first-word-fall-through FIFO.
// Storage depth is 2**log_depth words; the status flags come only from the registered occupancy count.
// Optional build macro RESYNC_FIFO_ERR_FLAGS_EN adds the sticky overflow_wr and underflow_rd error outputs.
module resync_fifo #(
  parameter int width     = 20,
  parameter int log_depth = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             val_wr,
  input  logic [width-1:0] data_wr,
  input  logic             val_rd,
  output logic [width-1:0] data_rd,
  output logic             empty_rd,
  output logic             almost_empty_rd,
  output logic             full_wr
`ifdef RESYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow_wr,
  output logic             underflow_rd
`endif
);

  localparam int depth = 1 << log_depth;

  localparam logic [log_depth-1:0] ptr_one   = {{(log_depth-1){1'b0}}, 1'b1};
  localparam logic [log_depth:0]   cnt_one   = {{log_depth{1'b0}}, 1'b1};
  localparam logic [log_depth:0]   cnt_depth = {1'b1, {log_depth{1'b0}}};

  logic [width-1:0]     mem [depth];
  logic [log_depth-1:0] wr_ptr;
  logic [log_depth-1:0] rd_ptr;
  logic [log_depth:0]   count;
  logic                 wr_ok;
  logic                 rd_ok;

  // Flags depend only on the registered count, so no input reaches a flag combinationally.
  assign empty_rd        = (count == '0);
  assign almost_empty_rd = (count <= cnt_one);
  assign full_wr         = (count == cnt_depth);

  // A request is accepted only when the flag of the current cycle allows it.
  assign wr_ok = val_wr && !full_wr;
  assign rd_ok = val_rd && !empty_rd;

  // The head word falls through; stale memory is hidden behind zeros while empty.
  assign data_rd = empty_rd ? '0 : mem[rd_ptr];

  // Storage write; the memory is never cleared, and reset blocks any write in its own cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= data_wr;
    end
  end

  // Pointers wrap naturally modulo depth; the count tracks the net change in occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ptr_one;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ptr_one;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
    end
  end

`ifdef RESYNC_FIFO_ERR_FLAGS_EN
  // Sticky error flags: set by any refused request and cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_wr  <= 1'b0;
      underflow_rd <= 1'b0;
    end else begin
      if (val_wr && full_wr) begin
        overflow_wr <= 1'b1;
      end
      if (val_rd && empty_rd) begin
        underflow_rd <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_resync_fifo.sv
// Testbench for resync_fifo at the default parameters (width 20, depth 8).
// When built with RESYNC_FIFO_ERR_FLAGS_EN, the sticky error outputs are connected and checked as well.
module tb_resync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val_wr = 1'b0;
  logic [19:0] data_wr = '0;
  logic        val_rd = 1'b0;
  logic [19:0] data_rd;
  logic        empty_rd;
  logic        almost_empty_rd;
  logic        full_wr;
`ifdef RESYNC_FIFO_ERR_FLAGS_EN
  logic        overflow_wr;
  logic        underflow_rd;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  resync_fifo #(.width(20), .log_depth(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .val_wr          (val_wr),
    .data_wr         (data_wr),
    .val_rd          (val_rd),
    .data_rd         (data_rd),
    .empty_rd        (empty_rd),
    .almost_empty_rd (almost_empty_rd),
    .full_wr         (full_wr)
`ifdef RESYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow_wr     (overflow_wr),
    .underflow_rd    (underflow_rd)
`endif
  );

  typedef struct {
    logic        rst;
    logic        val_wr;
    logic [19:0] data_wr;
    logic        val_rd;
    logic        e_empty;
    logic        e_aempty;
    logic        e_full;
    logic [19:0] e_data;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic vw, input logic [19:0] dw,
                              input logic vr, input logic e, input logic ae,
                              input logic f, input logic [19:0] d, input string nm);
    vec_t v;
    v.rst = r; v.val_wr = vw; v.data_wr = dw; v.val_rd = vr;
    v.e_empty = e; v.e_aempty = ae; v.e_full = f; v.e_data = d; v.name = nm;
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then compare the settled outputs.
  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; val_wr = v.val_wr; data_wr = v.data_wr; val_rd = v.val_rd;
    @(posedge clk);
    #1;
    total++;
    if ({empty_rd, almost_empty_rd, full_wr, data_rd} !== {v.e_empty, v.e_aempty, v.e_full, v.e_data}) begin
      bad++;
      $display("FAIL %s: got empty=%b aempty=%b full=%b data=%h, want empty=%b aempty=%b full=%b data=%h",
               v.name, empty_rd, almost_empty_rd, full_wr, data_rd,
               v.e_empty, v.e_aempty, v.e_full, v.e_data);
    end
  endtask

`ifdef RESYNC_FIFO_ERR_FLAGS_EN
  task automatic check_flags(input logic e_ovf, input logic e_unf, input string nm);
    total++;
    if ({overflow_wr, underflow_rd} !== {e_ovf, e_unf}) begin
      bad++;
      $display("FAIL %s: got overflow=%b underflow=%b, want overflow=%b underflow=%b",
               nm, overflow_wr, underflow_rd, e_ovf, e_unf);
    end
  endtask
`endif

  initial begin
    // Table: reset, thresholds, fill/overfill, drain.
    vecs.push_back(mk(1, 1, 20'h0aaaa, 0, 1, 1, 0, 20'h0, "reset_cycle1"));
    vecs.push_back(mk(1, 1, 20'h0bbbb, 0, 1, 1, 0, 20'h0, "reset_cycle2"));
    vecs.push_back(mk(0, 1, 20'h12345, 0, 0, 1, 0, 20'h12345, "thresh_one_word"));
    vecs.push_back(mk(0, 1, 20'h00002, 0, 0, 0, 0, 20'h12345, "thresh_two_words"));
    vecs.push_back(mk(0, 0, 20'h0, 1, 0, 1, 0, 20'h00002, "thresh_pop_to_one"));
    vecs.push_back(mk(0, 0, 20'h0, 1, 1, 1, 0, 20'h0, "thresh_pop_to_empty"));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 1, 20'(i), 0, 0, (i == 1), (i == 8), 20'h00001, $sformatf("fill_%0d", i)));
    vecs.push_back(mk(0, 1, 20'h00009, 0, 0, 0, 1, 20'h00001, "fill_9th_dropped"));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 0, 20'h0, 1, (k == 8), (k >= 7), 0, (k == 8) ? 20'h0 : 20'(k + 1),
                        $sformatf("drain_%0d", k)));

    foreach (vecs[i]) step(vecs[i]);

    // Simultaneous push/pop at count 4, running well past pointer wrap.
    step(mk(1, 0, 20'h0, 0, 1, 1, 0, 20'h0, "sim_reset"));
    for (int i = 0; i < 4; i++)
      step(mk(0, 1, 20'(20'h100 + i), 0, 0, (i == 0), 0, 20'h00100, $sformatf("sim_prefill_%0d", i)));
    for (int i = 0; i < 20; i++)
      step(mk(0, 1, 20'(20'h104 + i), 1, 0, 0, 0, 20'(20'h101 + i), $sformatf("sim_both_%0d", i)));
    for (int i = 0; i < 4; i++)
      step(mk(0, 0, 20'h0, 1, (i == 3), (i >= 2), 0, (i == 3) ? 20'h0 : 20'(20'h115 + i),
              $sformatf("sim_drain_%0d", i)));

    // Boundaries: push+pop while full drops the write; push+pop while empty drops the pop.
    step(mk(1, 0, 20'h0, 0, 1, 1, 0, 20'h0, "bnd_reset"));
`ifdef RESYNC_FIFO_ERR_FLAGS_EN
    check_flags(1'b0, 1'b0, "flags_after_reset");
`endif
    for (int i = 0; i < 8; i++)
      step(mk(0, 1, 20'(20'h0a0 + i), 0, 0, (i == 0), (i == 7), 20'h000a0, $sformatf("bnd_fill_%0d", i)));
    step(mk(0, 1, 20'h000ff, 1, 0, 0, 0, 20'h000a1, "bnd_full_wr_rd"));
    for (int i = 0; i < 7; i++)
      step(mk(0, 0, 20'h0, 1, (i == 6), (i >= 5), 0, (i == 6) ? 20'h0 : 20'(20'h0a2 + i),
              $sformatf("bnd_drain_%0d", i)));
    step(mk(0, 1, 20'h00055, 1, 0, 1, 0, 20'h00055, "bnd_empty_wr_rd"));
    step(mk(0, 0, 20'h0, 1, 1, 1, 0, 20'h0, "bnd_pop_last"));
`ifdef RESYNC_FIFO_ERR_FLAGS_EN
    check_flags(1'b1, 1'b1, "flags_set");
    step(mk(0, 0, 20'h0, 0, 1, 1, 0, 20'h0, "flags_idle1"));
    step(mk(0, 1, 20'h00033, 0, 0, 1, 0, 20'h00033, "flags_idle_write"));
    check_flags(1'b1, 1'b1, "flags_sticky");
    step(mk(1, 0, 20'h0, 0, 1, 1, 0, 20'h0, "flags_reset"));
    check_flags(1'b0, 1'b0, "flags_cleared");
`endif

    // Mid-operation reset discards contents; next write becomes the head.
    step(mk(1, 0, 20'h0, 0, 1, 1, 0, 20'h0, "mid_pre_reset"));
    for (int i = 0; i < 5; i++)
      step(mk(0, 1, 20'(20'h011 + i), 0, 0, (i == 0), 0, 20'h00011, $sformatf("mid_fill_%0d", i)));
    step(mk(1, 1, 20'h00099, 1, 1, 1, 0, 20'h0, "mid_reset_pulse"));
    step(mk(0, 1, 20'habcde, 0, 0, 1, 0, 20'habcde, "mid_first_write"));
    step(mk(0, 1, 20'h00077, 1, 0, 1, 0, 20'h00077, "mid_wr_rd"));
    step(mk(0, 0, 20'h0, 1, 1, 1, 0, 20'h0, "mid_final_pop"));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
